// File: rtl/des_sbox_engine.sv
// des_sbox_engine: DES S1..S8 substitution time-multiplexed over LANES lookups per cycle, optional P permutation
module des_sbox_engine #(
   parameter int LANES = 8,
   parameter int APPLY_P = 1
) (
   input  logic        wClk,
   input  logic        wResetN,
   input  logic        wInValid,
   output logic        wInReady,
   input  logic [0:47] wInData,
   output logic        wOutValid,
   input  logic        wOutReady,
   output logic [0:31] wOutData,
   output logic        wBusy
);
   localparam int N = 8 / LANES;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
      $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
   end
   // each box is 64 nibbles, row-major: nibble index = {row, column}
   localparam logic [0:255] SBOX [8] = '{
      {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };
   localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [0:47] opnd;
   logic [0:31] acc, perm;
   logic [CW-1:0] cnt;
   logic [2:0] grp [LANES];
   logic [3:0] nib [LANES];
   logic accept, last;

   function automatic logic [3:0] lookup(input logic [2:0] box, input logic [0:5] b);
      return SBOX[box][{b[0], b[5], b[1:4], 2'b00} +: 4];
   endfunction

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         grp[l] = 3'(int'(cnt) * LANES + l);
         nib[l] = lookup(grp[l], opnd[6 * grp[l] +: 6]);
      end
   end

   always_comb begin
      for (int i = 0; i < 32; i++) perm[i] = acc[P_TAB[i] - 1];
   end

   assign last = cnt == CW'(N - 1);
   assign wInReady = state == IDLE || (state == DONE && wOutReady);
   assign accept = wInValid && wInReady;
   assign wOutValid = state == DONE;
   assign wBusy = state == BUSY;
   assign wOutData = wOutValid ? (APPLY_P != 0 ? perm : acc) : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = accept ? BUSY : IDLE;
         BUSY: state_nxt = last ? DONE : BUSY;
         DONE: state_nxt = wOutReady ? (wInValid ? BUSY : IDLE) : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wClk or negedge wResetN) begin
      if (!wResetN) begin
         state <= IDLE;
         opnd <= '0;
         acc <= '0;
         cnt <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            opnd <= wInData;
            cnt <= '0;
         end else if (state == BUSY) begin
            for (int l = 0; l < LANES; l++) acc[4 * grp[l] +: 4] <= nib[l];
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule
